// File: rtl/posit_quire_accumulator.sv
// posit_quire_accumulator
// Streaming exact (quire) accumulator for decoded posit data. Each datum is
// aligned onto a wide fixed-point grid in stage 1 and summed in stage 2; one
// result is emitted per sow/eow framed window. The rts/rtr handshake matches
// the posit adder so this block chains directly onto its result port.

module posit_quire_accumulator #(
    parameter int POSIT_WIDTH = 8,
    parameter int POSIT_ES    = 1,
    parameter int SCALE_W     = 6,
    parameter int FRAC_W      = 4,
    parameter int MIN_SCALE   = -12,
    parameter int MAX_SCALE   = 12,
    parameter int QUIRE_W     = 48,
    parameter int CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rts_i,
    output logic                      rtr_o,
    input  logic                      sow_i,
    input  logic                      eow_i,
    input  logic                      sign_i,
    input  logic signed [SCALE_W-1:0] scale_i,
    input  logic [FRAC_W-1:0]         fraction_i,
    input  logic                      guard_i,
    input  logic                      round_i,
    input  logic                      sticky_i,
    input  logic                      zero_i,
    input  logic                      nar_i,
    output logic                      rts_o,
    input  logic                      rtr_i,
    output logic [QUIRE_W-1:0]        quire_o,
    output logic                      nar_o,
    output logic                      ovf_o,
    output logic [CNT_W-1:0]          count_o,
    output logic                      err_o
);

    // Magnitude is hidden bit + fraction + guard + round.
    localparam int MAG_W = FRAC_W + 3;
    // Scale arithmetic is done two bits wider so clamping and the
    // distance from the origin can never wrap.
    localparam int EXT_W = SCALE_W + 2;
    localparam logic signed [EXT_W-1:0] MIN_S = EXT_W'(MIN_SCALE);
    localparam logic signed [EXT_W-1:0] MAX_S = EXT_W'(MAX_SCALE);
    // Alignment origin implied by the source posit format.
    localparam int FORMAT_ORIGIN = -(2 ** POSIT_ES) * (POSIT_WIDTH - 2);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;

    // Sticky lies entirely below the quire LSB, so it cannot change the sum.
    logic unused_ok;
    assign unused_ok = ^{sticky_i, (FORMAT_ORIGIN == MIN_SCALE)};

    // Handshake
    logic process_en;
    logic xfer;

    assign process_en = rtr_i | ~rts_o;
    assign xfer       = rts_i & rtr_o;

    // One-entry skid buffer
    logic                      skid_valid;
    logic                      skid_sow;
    logic                      skid_eow;
    logic                      skid_sign;
    logic signed [SCALE_W-1:0] skid_scale;
    logic [FRAC_W-1:0]         skid_frac;
    logic                      skid_guard;
    logic                      skid_round;
    logic                      skid_zero;
    logic                      skid_nar;

    // Datum selected for stage 1 (skid has priority over the live input)
    logic                      sel_valid;
    logic                      sel_sow;
    logic                      sel_eow;
    logic                      sel_sign;
    logic signed [SCALE_W-1:0] sel_scale;
    logic [FRAC_W-1:0]         sel_frac;
    logic                      sel_guard;
    logic                      sel_round;
    logic                      sel_zero;
    logic                      sel_nar;

    // Alignment
    logic [QUIRE_W-1:0]        mag_ext;
    logic signed [EXT_W-1:0]   eff_scale;
    logic signed [EXT_W-1:0]   shift_amt;
    logic [EXT_W-1:0]          right_amt;
    logic [QUIRE_W-1:0]        aligned;
    logic [QUIRE_W-1:0]        addend;

    // Stage 1 registers
    logic                      s1_valid;
    logic                      s1_sow;
    logic                      s1_eow;
    logic                      s1_nar;
    logic [QUIRE_W-1:0]        s1_addend;

    // Stage 2 window state
    logic [0:0]                state;
    logic [QUIRE_W-1:0]        acc;
    logic [CNT_W-1:0]          cnt;
    logic                      nar_acc;
    logic                      ovf_acc;
    logic                      err_acc;

    logic [QUIRE_W-1:0]        sum;
    logic                      add_ovf;
    logic                      start_window;
    logic [QUIRE_W-1:0]        nxt_acc;
    logic [CNT_W-1:0]          nxt_cnt;
    logic                      nxt_nar;
    logic                      nxt_ovf;
    logic                      nxt_err;

    // rtr_o is the registered form of process_en
    always_ff @(posedge clk) begin
        if (rst) begin
            rtr_o <= 1'b0;
        end else begin
            rtr_o <= process_en;
        end
    end

    // Catch a datum accepted in a cycle where the pipeline is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid <= 1'b0;
            skid_sow   <= 1'b0;
            skid_eow   <= 1'b0;
            skid_sign  <= 1'b0;
            skid_scale <= '0;
            skid_frac  <= '0;
            skid_guard <= 1'b0;
            skid_round <= 1'b0;
            skid_zero  <= 1'b0;
            skid_nar   <= 1'b0;
        end else if (process_en) begin
            skid_valid <= 1'b0;
        end else if (xfer) begin
            skid_valid <= 1'b1;
            skid_sow   <= sow_i;
            skid_eow   <= eow_i;
            skid_sign  <= sign_i;
            skid_scale <= scale_i;
            skid_frac  <= fraction_i;
            skid_guard <= guard_i;
            skid_round <= round_i;
            skid_zero  <= zero_i;
            skid_nar   <= nar_i;
        end
    end

    // Pick the buffered datum first so ordering is preserved
    always_comb begin
        if (skid_valid) begin
            sel_valid = 1'b1;
            sel_sow   = skid_sow;
            sel_eow   = skid_eow;
            sel_sign  = skid_sign;
            sel_scale = skid_scale;
            sel_frac  = skid_frac;
            sel_guard = skid_guard;
            sel_round = skid_round;
            sel_zero  = skid_zero;
            sel_nar   = skid_nar;
        end else begin
            sel_valid = xfer;
            sel_sow   = sow_i;
            sel_eow   = eow_i;
            sel_sign  = sign_i;
            sel_scale = scale_i;
            sel_frac  = fraction_i;
            sel_guard = guard_i;
            sel_round = round_i;
            sel_zero  = zero_i;
            sel_nar   = nar_i;
        end
    end

    // Place the magnitude on the quire grid and apply the sign
    always_comb begin
        mag_ext              = '0;
        mag_ext[MAG_W-1:0]   = {1'b1, sel_frac, sel_guard, sel_round};
        eff_scale            = {{2{sel_scale[SCALE_W-1]}}, sel_scale};
        if (eff_scale > MAX_S) begin
            eff_scale = MAX_S;
        end
        shift_amt = eff_scale - MIN_S;
        right_amt = -shift_amt;
        if (shift_amt[EXT_W-1]) begin
            aligned = mag_ext >> right_amt;
        end else begin
            aligned = mag_ext << shift_amt;
        end
        if (sel_zero | sel_nar) begin
            addend = '0;
        end else if (sel_sign) begin
            addend = -aligned;
        end else begin
            addend = aligned;
        end
    end

    // Stage 1 holds the aligned addend and its framing
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sow    <= 1'b0;
            s1_eow    <= 1'b0;
            s1_nar    <= 1'b0;
            s1_addend <= '0;
        end else if (process_en) begin
            s1_valid  <= sel_valid;
            s1_sow    <= sel_sow;
            s1_eow    <= sel_eow;
            s1_nar    <= sel_nar;
            s1_addend <= addend;
        end
    end

    // Next window values: a new window restarts on IDLE or a stray sow
    always_comb begin
        sum          = acc + s1_addend;
        add_ovf      = (acc[QUIRE_W-1] == s1_addend[QUIRE_W-1]) &&
                       (sum[QUIRE_W-1] != acc[QUIRE_W-1]);
        start_window = (state == IDLE) || s1_sow;
        if (start_window) begin
            nxt_acc = s1_addend;
            nxt_cnt = CNT_W'(1);
            nxt_nar = s1_nar;
            nxt_ovf = 1'b0;
            nxt_err = !((state == IDLE) && s1_sow);
        end else begin
            nxt_acc = sum;
            nxt_cnt = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
            nxt_nar = nar_acc | s1_nar;
            nxt_ovf = ovf_acc | add_ovf;
            nxt_err = err_acc;
        end
    end

    // Window FSM and running accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            nar_acc <= 1'b0;
            ovf_acc <= 1'b0;
            err_acc <= 1'b0;
        end else if (process_en && s1_valid) begin
            acc     <= nxt_acc;
            cnt     <= nxt_cnt;
            nar_acc <= nxt_nar;
            ovf_acc <= nxt_ovf;
            err_acc <= nxt_err;
            state   <= s1_eow ? IDLE : ACCUM;
        end
    end

    // Publish the window result on eow and hold it until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            rts_o   <= 1'b0;
            quire_o <= '0;
            nar_o   <= 1'b0;
            ovf_o   <= 1'b0;
            count_o <= '0;
            err_o   <= 1'b0;
        end else if (process_en) begin
            rts_o <= s1_valid & s1_eow;
            if (s1_valid && s1_eow) begin
                quire_o <= nxt_acc;
                nar_o   <= nxt_nar;
                ovf_o   <= nxt_ovf;
                count_o <= nxt_cnt;
                err_o   <= nxt_err;
            end
        end
    end

endmodule

// File: tb/tb_posit_quire_accumulator.sv
// tb_posit_quire_accumulator
// Drives directed windows into a 48-bit and a 32-bit quire sharing the same
// inputs. A reference model predicts each window result when its eow datum
// is accepted; a monitor compares the DUT outputs against the queue head.

module tb_posit_quire_accumulator;

    typedef struct {
        logic [47:0] q;
        logic [31:0] q32;
        logic        nar;
        logic        ovf;
        logic        ovf32;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rts_i;
    logic        sow_i;
    logic        eow_i;
    logic        sign_i;
    logic [5:0]  scale_i;
    logic [3:0]  fraction_i;
    logic        guard_i;
    logic        round_i;
    logic        sticky_i;
    logic        zero_i;
    logic        nar_i;
    logic        rtr_i;

    logic        rtr_o;
    logic        rts_o;
    logic [47:0] quire_o;
    logic        nar_o;
    logic        ovf_o;
    logic [15:0] count_o;
    logic        err_o;

    logic        rtr32;
    logic        rts32;
    logic [31:0] quire32;
    logic        nar32;
    logic        ovf32;
    logic [15:0] count32;
    logic        err32;

    int passCount  = 0;
    int failCount  = 0;
    int totalChecks = 0;
    logic toggleMode = 1'b0;

    exp_t sbQueue[$];

    // Reference window state
    logic        mInWin = 1'b0;
    logic [47:0] mAcc48;
    logic [31:0] mAcc32;
    logic [15:0] mCnt;
    logic        mNar;
    logic        mOvf48;
    logic        mOvf32;
    logic        mErr;

    posit_quire_accumulator #(.QUIRE_W(48)) dut (
        .clk(clk), .rst(rst), .rts_i(rts_i), .rtr_o(rtr_o),
        .sow_i(sow_i), .eow_i(eow_i), .sign_i(sign_i), .scale_i(scale_i),
        .fraction_i(fraction_i), .guard_i(guard_i), .round_i(round_i),
        .sticky_i(sticky_i), .zero_i(zero_i), .nar_i(nar_i),
        .rts_o(rts_o), .rtr_i(rtr_i), .quire_o(quire_o), .nar_o(nar_o),
        .ovf_o(ovf_o), .count_o(count_o), .err_o(err_o)
    );

    posit_quire_accumulator #(.QUIRE_W(32)) dut32 (
        .clk(clk), .rst(rst), .rts_i(rts_i), .rtr_o(rtr32),
        .sow_i(sow_i), .eow_i(eow_i), .sign_i(sign_i), .scale_i(scale_i),
        .fraction_i(fraction_i), .guard_i(guard_i), .round_i(round_i),
        .sticky_i(sticky_i), .zero_i(zero_i), .nar_i(nar_i),
        .rts_o(rts32), .rtr_i(rtr_i), .quire_o(quire32), .nar_o(nar32),
        .ovf_o(ovf32), .count_o(count32), .err_o(err32)
    );

    // Free-running clock
    initial forever #5 clk = ~clk;

    // Downstream ready: steady high, or alternating when toggleMode is set
    initial begin
        rtr_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rtr_i = toggleMode ? ~rtr_i : 1'b1;
        end
    end

    // Hard stop in case something hangs outside a bounded wait
    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        totalChecks++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Exact value of a datum in quire LSB units (2^-18), truncated toward zero
    function automatic longint alignValue(input logic sg, input int sc, input logic [3:0] fr,
                                          input logic g, input logic r, input logic z, input logic n);
        longint mag;
        int     esc;
        int     sh;
        mag = 64 + 4 * longint'(fr) + 2 * longint'(g) + longint'(r);
        esc = (sc > 12) ? 12 : sc;
        sh  = esc + 12;
        if (sh >= 0) mag = mag * (longint'(1) << sh);
        else         mag = mag / (longint'(1) << (-sh));
        if (z || n) return 0;
        return sg ? -mag : mag;
    endfunction

    // Update the reference window with an accepted datum
    task automatic modelAccept(input logic s, input logic e, input logic sg, input int sc,
                               input logic [3:0] fr, input logic g, input logic r,
                               input logic z, input logic n);
        longint v;
        longint s48;
        longint s32;
        exp_t   ent;
        v = alignValue(sg, sc, fr, g, r, z, n);
        if (!mInWin || s) begin
            mErr   = mInWin ? 1'b1 : !s;
            mAcc48 = 48'(v);
            mAcc32 = 32'(v);
            mCnt   = 16'd1;
            mNar   = n;
            mOvf48 = 1'b0;
            mOvf32 = 1'b0;
        end else begin
            s48 = longint'($signed(mAcc48)) + v;
            s32 = longint'($signed(mAcc32)) + v;
            if (s48 > 64'sh7FFF_FFFF_FFFF || s48 < -64'sh8000_0000_0000) mOvf48 = 1'b1;
            if (s32 > 64'sh7FFF_FFFF || s32 < -64'sh8000_0000) mOvf32 = 1'b1;
            mAcc48 = 48'(s48);
            mAcc32 = 32'(s32);
            mCnt   = mCnt + 16'd1;
            mNar   = mNar | n;
        end
        mInWin = !e;
        if (e) begin
            ent.q     = mAcc48;
            ent.q32   = mAcc32;
            ent.nar   = mNar;
            ent.ovf   = mOvf48;
            ent.ovf32 = mOvf32;
            ent.err   = mErr;
            ent.cnt   = mCnt;
            sbQueue.push_back(ent);
        end
    endtask

    // Offer one datum and hold it until the DUT takes it
    task automatic applyStimulus(input logic s, input logic e, input logic sg, input int sc,
                                 input logic [3:0] fr, input logic g, input logic r,
                                 input logic z, input logic n);
        int waitCycles;
        waitCycles = 0;
        rts_i      = 1'b1;
        sow_i      = s;
        eow_i      = e;
        sign_i     = sg;
        scale_i    = 6'(sc);
        fraction_i = fr;
        guard_i    = g;
        round_i    = r;
        sticky_i   = g ^ r;
        zero_i     = z;
        nar_i      = n;
        @(negedge clk);
        while (!rtr_o && waitCycles < 200) begin
            @(negedge clk);
            waitCycles++;
        end
        if (rtr_o !== 1'b1) checkOutput("accept_timeout", 64'(rtr_o), 64'd1);
        else                modelAccept(s, e, sg, sc, fr, g, r, z, n);
        @(posedge clk);
        #1;
        rts_i = 1'b0;
    endtask

    task automatic doReset();
        rst   = 1'b1;
        rts_i = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_rtr", 64'(rtr_o), 64'd0);
        checkOutput("reset_rts", 64'(rts_o), 64'd0);
        checkOutput("reset_quire", 64'(quire_o), 64'd0);
        checkOutput("reset_count", 64'(count_o), 64'd0);
        checkOutput("reset_flags", 64'({nar_o, ovf_o, err_o}), 64'd0);
        checkOutput("reset_rtr32", 64'(rtr32), 64'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mInWin = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_release_rtr", 64'(rtr_o), 64'd1);
    endtask

    task automatic waitDrain();
        for (int k = 0; k < 100 && sbQueue.size() != 0; k++) @(posedge clk);
        #1;
        checkOutput("drain_empty", 64'(sbQueue.size()), 64'd0);
    endtask

    // Monitor: compare every valid output cycle against the queue head,
    // retire the entry when downstream takes it
    initial begin
        exp_t ent;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && rts_o === 1'b1) begin
                checkOutput("result_pending", 64'(sbQueue.size() != 0), 64'd1);
                if (sbQueue.size() != 0) begin
                    ent = sbQueue[0];
                    checkOutput("quire", 64'(quire_o), 64'(ent.q));
                    checkOutput("nar", 64'(nar_o), 64'(ent.nar));
                    checkOutput("ovf", 64'(ovf_o), 64'(ent.ovf));
                    checkOutput("count", 64'(count_o), 64'(ent.cnt));
                    checkOutput("err", 64'(err_o), 64'(ent.err));
                    checkOutput("rts32", 64'(rts32), 64'd1);
                    checkOutput("quire32", 64'(quire32), 64'(ent.q32));
                    checkOutput("ovf32", 64'(ovf32), 64'(ent.ovf32));
                    checkOutput("nar32_err32", 64'({nar32, err32}), 64'({ent.nar, ent.err}));
                    checkOutput("count32", 64'(count32), 64'(ent.cnt));
                    if (rtr_i) void'(sbQueue.pop_front());
                end
            end
        end
    end

    // Directed sequence
    initial begin
        rst = 1'b1; rts_i = 1'b0; sow_i = 1'b0; eow_i = 1'b0; sign_i = 1'b0;
        scale_i = '0; fraction_i = '0; guard_i = 1'b0; round_i = 1'b0;
        sticky_i = 1'b0; zero_i = 1'b0; nar_i = 1'b0;
        doReset();

        // 1.0 + 1.5 and its two-cycle latency
        applyStimulus(1, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 4'b1000, 0, 0, 0, 0);
        checkOutput("t1_rts_one_cycle", 64'(rts_o), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("t1_rts_two_cycles", 64'(rts_o), 64'd1);
        checkOutput("t1_quire", 64'(quire_o), 64'h0A_0000);
        checkOutput("t1_count", 64'(count_o), 64'd2);
        checkOutput("t1_flags", 64'({nar_o, ovf_o, err_o}), 64'd0);

        // Single-term windows +1.0 and -1.0
        applyStimulus(1, 1, 0, 0, 4'b0000, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        checkOutput("single_pos", 64'(quire_o), 64'h4_0000);
        applyStimulus(1, 1, 1, 0, 4'b0000, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        checkOutput("single_neg", 64'(quire_o), 64'hFFFF_FFFC_0000);

        // NaR and zero contribute nothing but NaR is flagged
        applyStimulus(1, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 5, 4'b1111, 1, 1, 0, 1);
        applyStimulus(0, 0, 1, 3, 4'b0101, 0, 1, 1, 0);
        applyStimulus(0, 1, 1, 0, 4'b0000, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        checkOutput("nar_window_quire", 64'(quire_o), 64'd0);
        checkOutput("nar_window_nar", 64'(nar_o), 64'd1);
        checkOutput("nar_window_count", 64'(count_o), 64'd4);

        // Top of range: 2 * 2^12 overflows only the 32-bit quire
        applyStimulus(1, 0, 0, 12, 4'b0000, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 12, 4'b0000, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        checkOutput("ovf32_flag", 64'(ovf32), 64'd1);
        checkOutput("ovf32_quire", 64'(quire32), 64'h8000_0000);
        checkOutput("ovf48_flag", 64'(ovf_o), 64'd0);

        // Clamp above MAX_SCALE, truncation below MIN_SCALE, full underflow
        applyStimulus(1, 0, 0, 20, 4'b0001, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, -14, 4'b1111, 1, 1, 0, 0);
        applyStimulus(0, 1, 0, -25, 4'b1111, 1, 1, 0, 0);
        @(posedge clk);
        #1;
        checkOutput("clamp_trunc_quire", 64'(quire_o), 64'h43FF_FFE1);
        waitDrain();

        // Streaming single-term windows under alternating back-pressure
        toggleMode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 1, i[0], i - 3, 4'(i * 3), i[1], i[2], 0, 0);
        end
        waitDrain();
        toggleMode = 1'b0;
        repeat (2) @(posedge clk);

        // Framing errors: missing sow, then a sow in the middle of a window
        doReset();
        applyStimulus(0, 0, 0, 1, 4'b0010, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 2, 4'b0100, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 3, 4'b0001, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, -2, 4'b0110, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 4, 4'b1001, 0, 1, 0, 0);
        @(posedge clk);
        #1;
        checkOutput("err_restart_flag", 64'(err_o), 64'd1);
        checkOutput("err_restart_count", 64'(count_o), 64'd2);
        waitDrain();

        // Reset in the middle of a window discards the partial sum
        applyStimulus(1, 0, 0, 6, 4'b1100, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 7, 4'b0011, 0, 0, 0, 0);
        doReset();
        applyStimulus(1, 0, 0, 1, 4'b0000, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 4'b1000, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        checkOutput("post_reset_quire", 64'(quire_o), 64'h14_0000);
        checkOutput("post_reset_err", 64'(err_o), 64'd0);
        waitDrain();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passCount, totalChecks);
        $finish;
    end

endmodule
